// File: rtl/tl_a_arb_2to1.sv
// Two-client TileLink-UL A-channel arbiter with source-routed D channel.
// Optional: define TL_A_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module tl_a_arb_2to1 (
   input  logic        clock,
   input  logic        reset,
   // client 0 A channel
   output logic        auto_in0_a_ready,
   input  logic        auto_in0_a_valid,
   input  logic [2:0]  auto_in0_a_bits_opcode,
   input  logic [2:0]  auto_in0_a_bits_param,
   input  logic [3:0]  auto_in0_a_bits_size,
   input  logic [3:0]  auto_in0_a_bits_source,
   input  logic [30:0] auto_in0_a_bits_address,
   input  logic [7:0]  auto_in0_a_bits_mask,
   input  logic [63:0] auto_in0_a_bits_data,
   input  logic        auto_in0_a_bits_corrupt,
   // client 0 D channel
   input  logic        auto_in0_d_ready,
   output logic        auto_in0_d_valid,
   output logic [2:0]  auto_in0_d_bits_opcode,
   output logic [1:0]  auto_in0_d_bits_param,
   output logic [3:0]  auto_in0_d_bits_size,
   output logic [3:0]  auto_in0_d_bits_source,
   output logic        auto_in0_d_bits_sink,
   output logic        auto_in0_d_bits_denied,
   output logic [63:0] auto_in0_d_bits_data,
   output logic        auto_in0_d_bits_corrupt,
   // client 1 A channel
   output logic        auto_in1_a_ready,
   input  logic        auto_in1_a_valid,
   input  logic [2:0]  auto_in1_a_bits_opcode,
   input  logic [2:0]  auto_in1_a_bits_param,
   input  logic [3:0]  auto_in1_a_bits_size,
   input  logic [3:0]  auto_in1_a_bits_source,
   input  logic [30:0] auto_in1_a_bits_address,
   input  logic [7:0]  auto_in1_a_bits_mask,
   input  logic [63:0] auto_in1_a_bits_data,
   input  logic        auto_in1_a_bits_corrupt,
   // client 1 D channel
   input  logic        auto_in1_d_ready,
   output logic        auto_in1_d_valid,
   output logic [2:0]  auto_in1_d_bits_opcode,
   output logic [1:0]  auto_in1_d_bits_param,
   output logic [3:0]  auto_in1_d_bits_size,
   output logic [3:0]  auto_in1_d_bits_source,
   output logic        auto_in1_d_bits_sink,
   output logic        auto_in1_d_bits_denied,
   output logic [63:0] auto_in1_d_bits_data,
   output logic        auto_in1_d_bits_corrupt,
   // manager A channel
   input  logic        auto_out_a_ready,
   output logic        auto_out_a_valid,
   output logic [2:0]  auto_out_a_bits_opcode,
   output logic [2:0]  auto_out_a_bits_param,
   output logic [3:0]  auto_out_a_bits_size,
   output logic [4:0]  auto_out_a_bits_source,
   output logic [30:0] auto_out_a_bits_address,
   output logic [7:0]  auto_out_a_bits_mask,
   output logic [63:0] auto_out_a_bits_data,
   output logic        auto_out_a_bits_corrupt,
   // manager D channel
   output logic        auto_out_d_ready,
   input  logic        auto_out_d_valid,
   input  logic [2:0]  auto_out_d_bits_opcode,
   input  logic [1:0]  auto_out_d_bits_param,
   input  logic [3:0]  auto_out_d_bits_size,
   input  logic [4:0]  auto_out_d_bits_source,
   input  logic        auto_out_d_bits_sink,
   input  logic        auto_out_d_bits_denied,
   input  logic [63:0] auto_out_d_bits_data,
   input  logic        auto_out_d_bits_corrupt
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        grant_q;
   logic        grant_d;
   logic [2:0]  cnt_q;
   logic [2:0]  cnt_d;

   logic        grant;
   logic        idle_grant;
   logic        fire;
   logic        multi;
   logic [2:0]  beats_m1;

   // ---------------------------------------------------------------
   // Idle-state grant selection
   // ---------------------------------------------------------------
`ifdef TL_A_ARB_ROUND_ROBIN_EN
   logic ptr_q;
   logic ptr_d;

   // Pointed-to client wins a tie; a lone requester always wins.
   always_comb begin
      idle_grant = auto_in1_a_valid;
      if (auto_in0_a_valid && auto_in1_a_valid) begin
         idle_grant = ptr_q;
      end
   end

   // Pointer flips away from the client whose message just completed.
   always_comb begin
      ptr_d = ptr_q;
      if (fire && (state_d == IDLE)) begin
         ptr_d = ~grant;
      end
   end

   // Round-robin pointer register, client 0 preferred after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: client 1 only wins when client 0 is not asking.
   assign idle_grant = ~auto_in0_a_valid & auto_in1_a_valid;
`endif

   assign grant = (state_q == LOCKED) ? grant_q : idle_grant;

   // ---------------------------------------------------------------
   // A channel mux (zero latency)
   // ---------------------------------------------------------------
   assign auto_out_a_valid =
      grant ? auto_in1_a_valid : auto_in0_a_valid;
   assign auto_out_a_bits_opcode =
      grant ? auto_in1_a_bits_opcode : auto_in0_a_bits_opcode;
   assign auto_out_a_bits_param =
      grant ? auto_in1_a_bits_param : auto_in0_a_bits_param;
   assign auto_out_a_bits_size =
      grant ? auto_in1_a_bits_size : auto_in0_a_bits_size;
   assign auto_out_a_bits_source = {
      grant,
      grant ? auto_in1_a_bits_source : auto_in0_a_bits_source
   };
   assign auto_out_a_bits_address =
      grant ? auto_in1_a_bits_address : auto_in0_a_bits_address;
   assign auto_out_a_bits_mask =
      grant ? auto_in1_a_bits_mask : auto_in0_a_bits_mask;
   assign auto_out_a_bits_data =
      grant ? auto_in1_a_bits_data : auto_in0_a_bits_data;
   assign auto_out_a_bits_corrupt =
      grant ? auto_in1_a_bits_corrupt : auto_in0_a_bits_corrupt;

   assign auto_in0_a_ready = ~grant & auto_out_a_ready;
   assign auto_in1_a_ready =  grant & auto_out_a_ready;

   assign fire = auto_out_a_valid & auto_out_a_ready;

   // Beats after the first for the message currently on the bus.
   always_comb begin
      multi = ((auto_out_a_bits_opcode == 3'd0) ||
               (auto_out_a_bits_opcode == 3'd1)) &&
              (auto_out_a_bits_size > 4'd3);
      case (auto_out_a_bits_size)
         4'd4:    beats_m1 = 3'd1;
         4'd5:    beats_m1 = 3'd3;
         default: beats_m1 = 3'd7;
      endcase
   end

   // ---------------------------------------------------------------
   // Grant lock FSM. In LOCKED, cnt==0 means the first beat has not
   // fired yet; otherwise cnt is the number of beats still to send.
   // ---------------------------------------------------------------

   // Next-state: hold grant until the message's last beat fires.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            grant_d = idle_grant;
            if (auto_out_a_valid) begin
               if (!fire) begin
                  state_d = LOCKED;
                  cnt_d   = 3'd0;
               end else if (multi) begin
                  state_d = LOCKED;
                  cnt_d   = beats_m1;
               end
            end
         end
         LOCKED: begin
            if (fire) begin
               if (cnt_q == 3'd0) begin
                  if (multi) begin
                     cnt_d = beats_m1;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (cnt_q == 3'd1) begin
                  cnt_d   = 3'd0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // State, grant and beat counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------
   // D channel routing by source MSB
   // ---------------------------------------------------------------
   assign auto_in0_d_valid =
      auto_out_d_valid & ~auto_out_d_bits_source[4];
   assign auto_in1_d_valid =
      auto_out_d_valid &  auto_out_d_bits_source[4];
   assign auto_out_d_ready = auto_out_d_bits_source[4] ?
      auto_in1_d_ready : auto_in0_d_ready;

   assign auto_in0_d_bits_opcode  = auto_out_d_bits_opcode;
   assign auto_in0_d_bits_param   = auto_out_d_bits_param;
   assign auto_in0_d_bits_size    = auto_out_d_bits_size;
   assign auto_in0_d_bits_source  = auto_out_d_bits_source[3:0];
   assign auto_in0_d_bits_sink    = auto_out_d_bits_sink;
   assign auto_in0_d_bits_denied  = auto_out_d_bits_denied;
   assign auto_in0_d_bits_data    = auto_out_d_bits_data;
   assign auto_in0_d_bits_corrupt = auto_out_d_bits_corrupt;

   assign auto_in1_d_bits_opcode  = auto_out_d_bits_opcode;
   assign auto_in1_d_bits_param   = auto_out_d_bits_param;
   assign auto_in1_d_bits_size    = auto_out_d_bits_size;
   assign auto_in1_d_bits_source  = auto_out_d_bits_source[3:0];
   assign auto_in1_d_bits_sink    = auto_out_d_bits_sink;
   assign auto_in1_d_bits_denied  = auto_out_d_bits_denied;
   assign auto_in1_d_bits_data    = auto_out_d_bits_data;
   assign auto_in1_d_bits_corrupt = auto_out_d_bits_corrupt;

endmodule
